narabe_engine: RTL and testbench
================================

NARABE_ENGINE -- requirements
Module: narabe_engine

Interface
REQ-001 SHALL have parameter N, default 3, board side length; legal range 3..5; a line is N in a row.
REQ-002 SHALL have derived constant IW = $clog2(N*N), cell-index width.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port new_game  input  1  one-cycle request to clear the board and restart.
REQ-006 SHALL have port move_valid  input  1  user move offered.
REQ-007 SHALL have port move_idx  input  IW  user cell index, row-major (0 = top-left).
REQ-008 SHALL have port move_ready  output  1  engine accepts a user move this cycle.
REQ-009 SHALL have port move_err  output  1  one-cycle pulse on a rejected move.
REQ-010 SHALL have port cpu_move_valid  output  1  one-cycle pulse when the CPU places a piece.
REQ-011 SHALL have port cpu_move_idx  output  IW  index of the CPU piece, held until the next CPU move.
REQ-012 SHALL have port board  output  2*N*N  cell i at bits [2i+1:2i]: 00 empty, 01 user (o), 10 CPU (x).
REQ-013 SHALL have ports isNotEnd, userWins, draw  output  1 each  game-status flags.
REQ-014 SHALL have port s  output  8  one-hot FSM state, for observation.

Function
REQ-015 SHALL implement the states WAIT_USER, CHECK_U, SCAN_WIN, SCAN_BLK, SCAN_FREE, PLACE, CHECK_C, DONE.
REQ-016 SHALL drive move_ready=1 only in WAIT_USER; a move is accepted when move_valid and move_ready are both high.
REQ-017 SHALL, on acceptance with move_idx<N*N and the cell empty, write 01 at the next edge and go to CHECK_U.
REQ-018 SHALL, when the index is out of range or the cell is occupied, pulse move_err, leave the board unchanged and stay in WAIT_USER.
REQ-019 SHALL make CHECK_U last one cycle with these exits: user has a complete line -> DONE, userWins=1; board full -> DONE, draw=1; otherwise -> SCAN_WIN with the scan index at 0.
REQ-020 SHALL make each scan state examine one cell per cycle, index 0..N*N-1 ascending; SCAN_WIN selects the first empty cell that completes a CPU line.
REQ-021 SHALL make SCAN_BLK select the first empty cell that would complete a user line.
REQ-022 SHALL make SCAN_FREE select the first empty cell.
REQ-023 SHALL, on a selection, go to PLACE; when a scan ends without a selection, go to the next scan state with the index reset to 0.
REQ-024 SHALL, in PLACE, write 10 at the selected cell, pulse cpu_move_valid, update cpu_move_idx and go to CHECK_C.
REQ-025 SHALL make CHECK_C last one cycle with these exits: CPU has a complete line -> DONE, userWins=0; board full -> DONE, draw=1; otherwise -> WAIT_USER.
REQ-026 SHALL hold isNotEnd=0 in DONE and 1 in every other state; board and flags SHALL hold in DONE.
REQ-027 SHALL, on new_game in any state, clear the board, move_err, userWins and draw, and enter WAIT_USER at the next edge; new_game SHALL win over a simultaneous move_valid, and that move SHALL be ignored.
REQ-028 SHALL detect lines combinationally over N rows, N columns and 2 diagonals; the hypothetical check SHALL use the board with the scanned cell overridden.

Reset
REQ-029 SHALL, while RST is high, force: state WAIT_USER; board 0; scan index 0; cpu_move_idx 0; move_err, cpu_move_valid, userWins, draw 0; isNotEnd 1.
REQ-030 SHALL, when RST is asserted mid-scan or mid-PLACE, discard the pending CPU move with no cpu_move_valid pulse.

Configuration
REQ-031 SHALL provide macro NARABE_STRATEGY_EN: when defined, SCAN_WIN and SCAN_BLK are used; when undefined, CHECK_U goes directly to SCAN_FREE and the SCAN_WIN/SCAN_BLK logic is not built (their bits in s stay 0).

Structure
REQ-032 SHALL place the cell_t enum (EMPTY/USER/CPU), the one-hot state_t enum and the status encodings in package narabe_pkg.
REQ-033 SHALL implement line detection in sub-module narabe_win_check (inputs: board, player; output: win), instantiated for actual and hypothetical checks.

Verification (N=3)
REQ-034 SHALL cover: macro on, reset, user idx 4 -> board[9:8]=01, 9+9+1 scan cycles, cpu_move_valid with cpu_move_idx=0.
REQ-035 SHALL cover: macro on, user 4, CPU 0, user 1 -> SCAN_BLK selects 7, cpu_move_idx=7.
REQ-036 SHALL cover: macro on, user 4, CPU 0, user 8 (CPU 1), user 6 -> SCAN_WIN selects 2, DONE, userWins=0, isNotEnd=0.
REQ-037 SHALL cover: macro off, user 3, CPU 0, user 4, CPU 1, user 5 -> DONE, userWins=1, isNotEnd=0, no CPU move.
REQ-038 SHALL cover: illegal moves (occupied idx 4, then idx 9) in WAIT_USER -> a one-cycle move_err pulse each, board unchanged.
REQ-039 SHALL cover: new_game during SCAN_FREE -> board=0 and WAIT_USER next cycle, no cpu_move_valid; RST mid-game -> reset values immediately.

Source files
------------

// File: rtl/narabe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : narabe_pkg
//  Description : Shared types for the N-in-a-row game engine: cell codes,
//                one-hot FSM states and the game-status encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package narabe_pkg;

    // Two-bit code stored per board cell
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        USER  = 2'b01,
        CPU   = 2'b10
    } cell_t;

    // One-hot engine state, exported on the s observation port
    typedef enum logic [7:0] {
        WAIT_USER = 8'b0000_0001,
        CHECK_U   = 8'b0000_0010,
        SCAN_WIN  = 8'b0000_0100,
        SCAN_BLK  = 8'b0000_1000,
        SCAN_FREE = 8'b0001_0000,
        PLACE     = 8'b0010_0000,
        CHECK_C   = 8'b0100_0000,
        DONE      = 8'b1000_0000
    } state_t;

    // Outcome of the current game; drives userWins / draw
    typedef enum logic [1:0] {
        ST_PLAY     = 2'b00,
        ST_USER_WIN = 2'b01,
        ST_CPU_WIN  = 2'b10,
        ST_DRAW     = 2'b11
    } status_t;

endpackage
`default_nettype wire

// File: rtl/narabe_if.sv
`default_nettype none
// ============================================================================
//  Module      : narabe_if
//  Description : Move handshake, CPU move report and board/status bus of the
//                game engine. master = player/host side, slave = engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface narabe_if #(
    parameter int N = 3
);
    localparam int IW = $clog2(N * N);

    logic              new_game;
    logic              move_valid;
    logic [IW-1:0]     move_idx;
    logic              move_ready;
    logic              move_err;
    logic              cpu_move_valid;
    logic [IW-1:0]     cpu_move_idx;
    logic [2*N*N-1:0]  board;
    logic              isNotEnd;
    logic              userWins;
    logic              draw;
    logic [7:0]        s;

    modport master (
        output new_game, move_valid, move_idx,
        input  move_ready, move_err, cpu_move_valid, cpu_move_idx,
        input  board, isNotEnd, userWins, draw, s
    );

    modport slave (
        input  new_game, move_valid, move_idx,
        output move_ready, move_err, cpu_move_valid, cpu_move_idx,
        output board, isNotEnd, userWins, draw, s
    );

endinterface
`default_nettype wire

// File: rtl/narabe_win_check.sv
`default_nettype none
// ============================================================================
//  Module      : narabe_win_check
//  Description : Combinational line detector. win is high when the given
//                player owns every cell of any row, column or diagonal.
//  Revision    : 1.0 - initial release
// ============================================================================
module narabe_win_check
    import narabe_pkg::*;
#(
    parameter int N = 3
) (
    input  wire logic [2*N*N-1:0] board,
    input  var  cell_t            player,
    output logic                  win
);

    logic [N-1:0] w_row;
    logic [N-1:0] w_col;
    logic         w_diag;
    logic         w_anti;

    // A line survives only if no cell on it differs from the player's code
    always_comb begin
        w_row  = '1;
        w_col  = '1;
        w_diag = 1'b1;
        w_anti = 1'b1;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (board[2*(r*N+c) +: 2] != player) w_row[r] = 1'b0;
                if (board[2*(c*N+r) +: 2] != player) w_col[r] = 1'b0;
            end
            if (board[2*(r*N+r) +: 2] != player)       w_diag = 1'b0;
            if (board[2*(r*N+N-1-r) +: 2] != player)   w_anti = 1'b0;
        end
        win = (|w_row) | (|w_col) | w_diag | w_anti;
    end

endmodule
`default_nettype wire

// File: rtl/narabe_engine.sv
`default_nettype none
// ============================================================================
//  Module      : narabe_engine
//  Description : N-in-a-row game engine. Accepts user moves, checks for a
//                finished game, then scans the board one cell per cycle to
//                pick and place the CPU move.
//                Build option NARABE_STRATEGY_EN: when defined the CPU first
//                looks for a winning cell, then a blocking cell, before
//                falling back to the first free cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module narabe_engine
    import narabe_pkg::*;
#(
    parameter int N = 3
) (
    input  wire logic CLK,
    input  wire logic RST,
    narabe_if.slave   io
);

    localparam int            c_NC   = N * N;
    localparam int            IW     = $clog2(c_NC);
    localparam int            c_BW   = 2 * c_NC;
    localparam logic [IW-1:0] c_LAST = IW'(c_NC - 1);

    state_t          r_state;
    state_t          w_next;
    status_t         r_status;
    logic [c_BW-1:0] r_board;
    logic [IW-1:0]   r_scan;
    logic [IW-1:0]   r_sel;
    logic [IW-1:0]   r_cpu_idx;
    logic            r_err;
    logic            r_cpu_vld;

    logic            w_full;
    logic            w_move_ok;
    logic            w_scan_empty;
    logic            w_scan_last;
    logic            w_accept;
    logic            w_reject;
    logic            w_select;
    logic            w_user_win;
    logic            w_cpu_win;

    // Board decode: fullness, whether the offered cell is free (an index past
    // the board never matches, so it reads as not free), and the scanned cell
    always_comb begin
        w_full       = 1'b1;
        w_move_ok    = 1'b0;
        w_scan_empty = 1'b0;
        for (int i = 0; i < c_NC; i++) begin
            if (r_board[2*i +: 2] == EMPTY) begin
                w_full = 1'b0;
                if (io.move_idx == IW'(i)) w_move_ok    = 1'b1;
                if (r_scan == IW'(i))      w_scan_empty = 1'b1;
            end
        end
    end

    assign w_scan_last = (r_scan == c_LAST);

    narabe_win_check #(.N(N)) u_user_win (
        .board  (r_board),
        .player (USER),
        .win    (w_user_win)
    );

    narabe_win_check #(.N(N)) u_cpu_win (
        .board  (r_board),
        .player (CPU),
        .win    (w_cpu_win)
    );

`ifdef NARABE_STRATEGY_EN
    logic [c_BW-1:0] w_hyp_cpu;
    logic [c_BW-1:0] w_hyp_user;
    logic            w_hyp_cpu_win;
    logic            w_hyp_user_win;

    // Copies of the board with the scanned cell claimed by each player
    always_comb begin
        w_hyp_cpu  = r_board;
        w_hyp_user = r_board;
        for (int i = 0; i < c_NC; i++) begin
            if (r_scan == IW'(i)) begin
                w_hyp_cpu[2*i +: 2]  = CPU;
                w_hyp_user[2*i +: 2] = USER;
            end
        end
    end

    narabe_win_check #(.N(N)) u_hyp_cpu (
        .board  (w_hyp_cpu),
        .player (CPU),
        .win    (w_hyp_cpu_win)
    );

    narabe_win_check #(.N(N)) u_hyp_user (
        .board  (w_hyp_user),
        .player (USER),
        .win    (w_hyp_user_win)
    );
`endif

    // Next-state logic and per-cycle strobes; new_game overrides everything
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        w_select = 1'b0;
        case (r_state)
            WAIT_USER: begin
                if (io.move_valid) begin
                    if (w_move_ok) begin
                        w_accept = 1'b1;
                        w_next   = CHECK_U;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            CHECK_U: begin
                if (w_user_win || w_full) begin
                    w_next = DONE;
                end else begin
`ifdef NARABE_STRATEGY_EN
                    w_next = SCAN_WIN;
`else
                    w_next = SCAN_FREE;
`endif
                end
            end
`ifdef NARABE_STRATEGY_EN
            SCAN_WIN: begin
                if (w_scan_empty && w_hyp_cpu_win) begin
                    w_select = 1'b1;
                    w_next   = PLACE;
                end else if (w_scan_last) begin
                    w_next = SCAN_BLK;
                end
            end
            SCAN_BLK: begin
                if (w_scan_empty && w_hyp_user_win) begin
                    w_select = 1'b1;
                    w_next   = PLACE;
                end else if (w_scan_last) begin
                    w_next = SCAN_FREE;
                end
            end
`endif
            SCAN_FREE: begin
                if (w_scan_empty) begin
                    w_select = 1'b1;
                    w_next   = PLACE;
                end else if (w_scan_last) begin
                    // Unreachable while CHECK_U screens out a full board
                    w_next = CHECK_C;
                end
            end
            PLACE: begin
                w_next = CHECK_C;
            end
            CHECK_C: begin
                if (w_cpu_win || w_full) w_next = DONE;
                else                     w_next = WAIT_USER;
            end
            DONE: begin
                w_next = DONE;
            end
            default: begin
                w_next = WAIT_USER;
            end
        endcase
        if (io.new_game) begin
            w_next   = WAIT_USER;
            w_accept = 1'b0;
            w_reject = 1'b0;
            w_select = 1'b0;
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= WAIT_USER;
        else     r_state <= w_next;
    end

    // Board, scan pointer, CPU move report and game outcome
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_board   <= '0;
            r_scan    <= '0;
            r_sel     <= '0;
            r_cpu_idx <= '0;
            r_err     <= 1'b0;
            r_cpu_vld <= 1'b0;
            r_status  <= ST_PLAY;
        end else begin
            r_err     <= 1'b0;
            r_cpu_vld <= 1'b0;
            if (io.new_game) begin
                r_board  <= '0;
                r_scan   <= '0;
                r_status <= ST_PLAY;
            end else begin
                r_err <= w_reject;
                if (w_next != r_state)
                    r_scan <= '0;
                else if (r_state inside {SCAN_WIN, SCAN_BLK, SCAN_FREE})
                    r_scan <= r_scan + 1'b1;
                if (w_select) r_sel <= r_scan;
                for (int i = 0; i < c_NC; i++) begin
                    if (w_accept && (io.move_idx == IW'(i)))
                        r_board[2*i +: 2] <= USER;
                    if ((r_state == PLACE) && (r_sel == IW'(i)))
                        r_board[2*i +: 2] <= CPU;
                end
                if (r_state == PLACE) begin
                    r_cpu_idx <= r_sel;
                    r_cpu_vld <= 1'b1;
                end
                if ((r_state == CHECK_U) && (w_next == DONE))
                    r_status <= w_user_win ? ST_USER_WIN : ST_DRAW;
                if ((r_state == CHECK_C) && (w_next == DONE))
                    r_status <= w_cpu_win ? ST_CPU_WIN : ST_DRAW;
            end
        end
    end

    assign io.move_ready     = (r_state == WAIT_USER);
    assign io.move_err       = r_err;
    assign io.cpu_move_valid = r_cpu_vld;
    assign io.cpu_move_idx   = r_cpu_idx;
    assign io.board          = r_board;
    assign io.isNotEnd       = (r_state != DONE);
    assign io.userWins       = (r_status == ST_USER_WIN);
    assign io.draw           = (r_status == ST_DRAW);
    assign io.s              = r_state;

endmodule
`default_nettype wire

// File: tb/tb_narabe_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_narabe_engine
//  Description : Self-checking bench for narabe_engine (N=3). Directed games
//                push the expected CPU moves and error pulses into queues; a
//                monitor pops and compares whenever the engine reports one.
//                Expectations follow the NARABE_STRATEGY_EN build option.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_narabe_engine;

    localparam int N    = 3;
    localparam int c_NC = N * N;
    localparam int IW   = $clog2(c_NC);
    localparam int c_BW = 2 * c_NC;

`ifdef NARABE_STRATEGY_EN
    localparam int c_LAT_FIRST = 22;  // CHECK_U + 9 win + 9 block + 1 free + PLACE, seen a cycle later
    localparam int c_CPU_BLOCK = 7;   // blocks column 1,4,7
`else
    localparam int c_LAT_FIRST = 4;   // CHECK_U + 1 free + PLACE, seen a cycle later
    localparam int c_CPU_BLOCK = 2;   // first free cell
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    narabe_if #(.N(N)) bus ();

    narabe_engine #(.N(N)) dut (
        .CLK (clk),
        .RST (rst),
        .io  (bus)
    );

    int               checks   = 0;
    int               failures = 0;
    int               err_seen = 0;
    int               exp_cpu[$];
    logic [c_BW-1:0]  exp_err[$];
    logic [c_BW-1:0]  exp_board;
    int               lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired before the required event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 200; k++) begin
            if (bus.move_ready === 1'b1) return;
            tick();
        end
        fail_now("move_ready_timeout");
    endtask

    // Offer a legal move; cpu >= 0 is the CPU reply the engine must make
    task automatic user_move(input int idx, input int cpu, output int latency);
        bit got;
        got     = 1'b0;
        latency = 0;
        wait_ready();
        if (cpu >= 0) exp_cpu.push_back(cpu);
        bus.move_idx   = IW'(idx);
        bus.move_valid = 1'b1;
        tick();
        bus.move_valid = 1'b0;
        exp_board[2*idx +: 2] = 2'b01;
        check("user_cell_written", bus.board, exp_board);
        if (cpu >= 0) begin
            for (int k = 1; k <= 100 && !got; k++) begin
                @(negedge clk);
                if (bus.cpu_move_valid === 1'b1) begin
                    got     = 1'b1;
                    latency = k;
                end
            end
            if (!got) begin
                fail_now("cpu_move_timeout");
            end else begin
                exp_board[2*cpu +: 2] = 2'b10;
                check("cpu_cell_written", bus.board, exp_board);
            end
        end
    endtask

    // Offer an illegal move: exactly one error pulse, board untouched
    task automatic reject_move(input int idx);
        int e0;
        wait_ready();
        exp_err.push_back(exp_board);
        e0             = err_seen;
        bus.move_idx   = IW'(idx);
        bus.move_valid = 1'b1;
        tick();
        bus.move_valid = 1'b0;
        check("reject_stays_wait", bus.s, 8'h01);
        check("reject_board", bus.board, exp_board);
        repeat (3) tick();
        check("reject_err_pulses", err_seen - e0, 1);
    endtask

    task automatic start_new_game();
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        exp_board    = '0;
        check("ng_state", bus.s, 8'h01);
        check("ng_board", bus.board, '0);
        check("ng_flags", {bus.isNotEnd, bus.userWins, bus.draw, bus.move_err}, 4'b1000);
    endtask

    // Scoreboard monitor: every reported CPU move and error pulse is matched
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cpu_move_valid === 1'b1) begin
                if (exp_cpu.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cpu_unexpected: actual idx=%0d required=no CPU move", bus.cpu_move_idx);
                end else begin
                    check("cpu_move_idx", bus.cpu_move_idx, exp_cpu.pop_front());
                end
            end
            if (bus.move_err === 1'b1) begin
                err_seen++;
                if (exp_err.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL err_unexpected: actual move_err=1 required=0");
                end else begin
                    check("err_board_unchanged", bus.board, exp_err.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        int e0;
        bus.new_game   = 1'b0;
        bus.move_valid = 1'b0;
        bus.move_idx   = '0;
        exp_board      = '0;

        // ---- reset values while RST is high
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", bus.s, 8'h01);
        check("rst_board", bus.board, '0);
        check("rst_flags", {bus.isNotEnd, bus.userWins, bus.draw, bus.move_err, bus.cpu_move_valid}, 5'b10000);
        check("rst_cpu_idx", bus.cpu_move_idx, '0);
        check("rst_ready", bus.move_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // ---- game 1: first move, illegal moves, block response
        user_move(4, 0, lat);
        check("first_cpu_latency", lat, c_LAT_FIRST);
        reject_move(4);
        reject_move(9);
        reject_move(0);
        user_move(1, c_CPU_BLOCK, lat);

        // ---- new_game wins over a simultaneous move
        wait_ready();
        e0             = err_seen;
        bus.move_idx   = IW'(5);
        bus.move_valid = 1'b1;
        bus.new_game   = 1'b1;
        tick();
        bus.move_valid = 1'b0;
        bus.new_game   = 1'b0;
        exp_board      = '0;
        check("ng_move_state", bus.s, 8'h01);
        check("ng_move_board", bus.board, '0);
        repeat (3) tick();
        check("ng_move_board_later", bus.board, '0);
        check("ng_move_no_err", err_seen - e0, 0);

        // ---- game 2: CPU completes row 0
        user_move(4, 0, lat);
        user_move(8, 1, lat);
        user_move(6, 2, lat);
        tick();
        check("cpuwin_state", bus.s, 8'h80);
        check("cpuwin_flags", {bus.isNotEnd, bus.userWins, bus.draw, bus.move_ready}, 4'b0000);
        e0             = err_seen;
        bus.move_idx   = IW'(3);
        bus.move_valid = 1'b1;
        repeat (3) tick();
        bus.move_valid = 1'b0;
        check("done_hold_board", bus.board, exp_board);
        check("done_hold_state", bus.s, 8'h80);
        check("done_no_err", err_seen - e0, 0);

        // ---- game 3: build-dependent endings
        start_new_game();
`ifdef NARABE_STRATEGY_EN
        user_move(3, 0, lat);
        user_move(4, 5, lat);
`else
        user_move(3, 0, lat);
        user_move(4, 1, lat);
        user_move(5, -1, lat);
        tick();
        check("userwin_state", bus.s, 8'h80);
        check("userwin_flags", {bus.isNotEnd, bus.userWins, bus.draw}, 3'b010);
        repeat (25) tick();
        check("userwin_hold_state", bus.s, 8'h80);
        check("userwin_hold_board", bus.board, exp_board);

        start_new_game();
        user_move(4, 0, lat);
        user_move(3, 1, lat);
        user_move(2, 5, lat);
        user_move(7, 6, lat);
        user_move(8, -1, lat);
        tick();
        check("draw_state", bus.s, 8'h80);
        check("draw_flags", {bus.isNotEnd, bus.userWins, bus.draw}, 3'b001);
`endif

        // ---- new_game while the CPU is picking a free cell
        start_new_game();
        wait_ready();
        bus.move_idx   = IW'(4);
        bus.move_valid = 1'b1;
        tick();
        bus.move_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (bus.s === 8'h10) found = 1'b1;
            else                 tick();
        end
        if (!found) fail_now("scan_free_timeout");
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        exp_board    = '0;
        check("ng_scan_state", bus.s, 8'h01);
        check("ng_scan_board", bus.board, '0);
        check("ng_scan_no_cpu", bus.cpu_move_valid, 1'b0);
        repeat (5) tick();
        check("ng_scan_state_later", bus.s, 8'h01);

        // ---- asynchronous reset in the middle of a CPU turn
        user_move(4, -1, lat);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_state", bus.s, 8'h01);
        check("midrst_board", bus.board, '0);
        check("midrst_cpu_idx", bus.cpu_move_idx, '0);
        check("midrst_flags", {bus.isNotEnd, bus.userWins, bus.draw, bus.cpu_move_valid}, 4'b1000);
        @(negedge clk);
        rst       = 1'b0;
        exp_board = '0;
        repeat (5) tick();
        check("postrst_state", bus.s, 8'h01);
        check("postrst_board", bus.board, '0);

        // ---- engine plays again after reset
        user_move(8, 0, lat);
        repeat (3) tick();

        check("cpu_queue_drained", exp_cpu.size(), 0);
        check("err_queue_drained", exp_err.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
